// File: rtl/register_file_32x32.sv
// 32 x 32-bit register file: one write port, two registered read ports, R0 reads as zero.
// Read and write strobes are mutually exclusive; asserting both is a no-op.
module register_file_32x32 (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        READ,
  input  logic        WRITE,
  input  logic [4:0]  ADDR_R1,
  input  logic [4:0]  ADDR_R2,
  input  logic [4:0]  ADDR_W,
  input  logic [31:0] DATA_W,
  output logic [31:0] DATA_R1,
  output logic [31:0] DATA_R2
);

  logic        wr_cmd;
  logic        rd_cmd;
  logic [31:0] dec_onehot;
  logic [31:0] load_en;
  logic [31:0] entry_q [1:31];
  logic [31:0] mux_r1;
  logic [31:0] mux_r2;
  logic [31:0] data_r1_q, data_r1_d;
  logic [31:0] data_r2_q, data_r2_d;

  assign wr_cmd     = WRITE & ~READ;
  assign rd_cmd     = READ & ~WRITE;
  assign dec_onehot = 32'd1 << ADDR_W;
  assign load_en    = dec_onehot & {32{wr_cmd}};

  // Entry 0 has no storage; its load enable is simply left unused.
  genvar gi;
  generate
    for (gi = 1; gi < 32; gi++) begin : g_entry
      always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
          entry_q[gi] <= '0;
        end else if (load_en[gi]) begin
          entry_q[gi] <= DATA_W;
        end
      end
    end
  endgenerate

  always_comb begin
    mux_r1 = '0;
    mux_r2 = '0;
    for (int i = 1; i < 32; i++) begin
      if (ADDR_R1 == 5'(i)) mux_r1 = entry_q[i];
      if (ADDR_R2 == 5'(i)) mux_r2 = entry_q[i];
    end
  end

  always_comb begin
    data_r1_d = data_r1_q;
    data_r2_d = data_r2_q;
    if (rd_cmd) begin
      data_r1_d = mux_r1;
      data_r2_d = mux_r2;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      data_r1_q <= '0;
      data_r2_q <= '0;
    end else begin
      data_r1_q <= data_r1_d;
      data_r2_q <= data_r2_d;
    end
  end

  assign DATA_R1 = data_r1_q;
  assign DATA_R2 = data_r2_q;

endmodule

// File: tb/tb_register_file_32x32.sv
// Self-checking bench for register_file_32x32: a reference array feeds a queue of
// expected read results that are popped and compared after each read edge.
module tb_register_file_32x32;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        READ;
  logic        WRITE;
  logic [4:0]  ADDR_R1;
  logic [4:0]  ADDR_R2;
  logic [4:0]  ADDR_W;
  logic [31:0] DATA_W;
  logic [31:0] DATA_R1;
  logic [31:0] DATA_R2;

  register_file_32x32 dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .READ    (READ),
    .WRITE   (WRITE),
    .ADDR_R1 (ADDR_R1),
    .ADDR_R2 (ADDR_R2),
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .DATA_R1 (DATA_R1),
    .DATA_R2 (DATA_R2)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] exp_r1;
    logic [31:0] exp_r2;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] model [32];
  logic [31:0] out1_m, out2_m;
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
      $display("ok   %-12s got=%08h", tag, obs);
    end else begin
      $display("FAIL %-12s got=%08h want=%08h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) model[i] = '0;
    out1_m = '0;
    out2_m = '0;
  endtask

  task automatic do_write(input logic [4:0] a, input logic [31:0] d);
    @(negedge CLK);
    READ = 1'b0; WRITE = 1'b1; ADDR_W = a; DATA_W = d;
    @(posedge CLK); #1;
    if (a != 5'd0) model[a] = d;
    WRITE = 1'b0;
  endtask

  task automatic do_read(input string tag, input logic [4:0] a1, input logic [4:0] a2);
    exp_t e;
    @(negedge CLK);
    READ = 1'b1; WRITE = 1'b0; ADDR_R1 = a1; ADDR_R2 = a2;
    out1_m = model[a1];
    out2_m = model[a2];
    sb_q.push_back('{out1_m, out2_m});
    @(posedge CLK); #1;
    READ = 1'b0;
    e = sb_q.pop_front();
    check({tag, "_r1"}, DATA_R1, e.exp_r1);
    check({tag, "_r2"}, DATA_R2, e.exp_r2);
  endtask

  task automatic do_idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      READ = 1'b0; WRITE = 1'b0;
      @(posedge CLK); #1;
    end
  endtask

  initial begin
    RESET = 1'b0; READ = 1'b0; WRITE = 1'b0;
    ADDR_R1 = '0; ADDR_R2 = '0; ADDR_W = '0; DATA_W = '0;
    model_clear();
    repeat (3) @(posedge CLK);
    #1;
    check("rst_r1", DATA_R1, 32'h0);
    check("rst_r2", DATA_R2, 32'h0);
    @(negedge CLK);
    RESET = 1'b1;

    // Mid-cycle reset after loading R5 and driving it onto both outputs
    do_write(5'd5, 32'hDEADBEEF);
    do_read("r5_pre", 5'd5, 5'd5);
    @(posedge CLK); #3;
    RESET = 1'b0;
    #1;
    model_clear();
    check("arst_r1", DATA_R1, 32'h0);
    check("arst_r2", DATA_R2, 32'h0);
    @(negedge CLK);
    RESET = 1'b1;
    do_read("r5_post", 5'd5, 5'd5);

    do_write(5'd7, 32'h12345678);
    do_write(5'd31, 32'hFFFFFFFF);
    do_read("wr_rd", 5'd7, 5'd31);

    // Illegal command must neither write nor read; outputs hold through idle
    @(negedge CLK);
    READ = 1'b1; WRITE = 1'b1; ADDR_W = 5'd7; DATA_W = 32'h0;
    ADDR_R1 = 5'd5; ADDR_R2 = 5'd5;
    @(posedge CLK); #1;
    READ = 1'b0; WRITE = 1'b0;
    do_idle(3);
    check("hold_r1", DATA_R1, out1_m);
    check("hold_r2", DATA_R2, out2_m);
    do_read("r7_again", 5'd7, 5'd7);

    do_write(5'd0, 32'hA5A5A5A5);
    do_read("r0", 5'd0, 5'd0);

    for (int k = 1; k < 32; k++) do_write(5'(k), 32'(k) * 32'h01010101);
    for (int k = 1; k < 32; k++) do_read($sformatf("sweep%0d", k), 5'(k), 5'(31 - k));

    // Back-to-back alternating write/read
    for (int k = 0; k < 4; k++) begin
      do_write(5'(k + 10), $urandom);
      do_read($sformatf("b2b%0d", k), 5'(k + 10), 5'(k + 9));
    end

    do_write(5'd3, 32'h1);
    do_write(5'd3, 32'h2);
    do_read("same_addr", 5'd3, 5'd3);

    if (sb_q.size() != 0) check("sb_empty", 32'(sb_q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule
